// File: rtl/ethercat_pkg.sv
// Shared definitions for the EtherCAT sync-manager mailbox channel.
//   DEPTH_DEFAULT : default mailbox buffer size in bytes
//   pdi_state_t   : PDI read FSM encoding (IDLE -> READ -> ACK -> IDLE)
package ethercat_pkg;

  localparam int DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    PDI_IDLE = 2'd0,
    PDI_READ = 2'd1,
    PDI_ACK  = 2'd2
  } pdi_state_t;

endpackage

// File: rtl/ethercat_dpram.sv
// Single-port synchronous RAM, DEPTH x 8, read-first.
//   clk   : clock
//   we    : write enable (write wins over the read of the same cycle)
//   addr  : byte address
//   wdata : write data
//   rdata : registered read data of addr, valid the cycle after the access
module ethercat_dpram #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; contents must survive a
  // reset, and a reset loop over every word would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ethercat_sm_mailbox.sv
// EtherCAT sync-manager mailbox channel (ECAT writes, PDI reads).
//   rxc, RST                 : clock, synchronous active-high reset
//   sm_enable/sm_start/sm_len: channel enable and physical window
//   bus_*                    : FMMU-side strobes; window is write-only from ECAT
//   pdi_rd/pdi_addr          : PDI read request, byte offset in window
//   pdi_rdata/pdi_ack        : PDI read result, 2-cycle latency when uncontended
//   mbx_full/mbx_irq         : complete unread mailbox, rising-edge pulse
//   sub_wkc                  : working-counter increment for the datagram
module ethercat_sm_mailbox
  import ethercat_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        rxc,
  input  logic        RST,
  input  logic        sm_enable,
  input  logic [15:0] sm_start,
  input  logic [7:0]  sm_len,
  input  logic [15:0] bus_address,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [7:0]  bus_data_out,
  output logic [7:0]  bus_data_in,
  output logic        bus_match,
  input  logic        pdi_rd,
  input  logic [7:0]  pdi_addr,
  output logic [7:0]  pdi_rdata,
  output logic        pdi_ack,
  output logic        mbx_full,
  output logic        mbx_irq,
  output logic [1:0]  sub_wkc
);

  localparam int AW = $clog2(DEPTH);

  // Window decode in 17 bits so a window near 0xFFFF never wraps to 0x0000.
  logic [16:0] addr_x, start_x, win_end;
  logic        hit, last_wr, en_q, en_fall, seen, wkc_q;
  logic [AW-1:0] wr_off;

  assign addr_x  = {1'b0, bus_address};
  assign start_x = {1'b0, sm_start};
  assign win_end = start_x + {9'd0, sm_len} - 17'd1;
  assign hit     = sm_enable && (sm_len != 8'd0) &&
                   (addr_x >= start_x) && (addr_x <= win_end);

  assign bus_match   = hit && bus_wr && !bus_rd && !mbx_full && !RST;
  assign bus_data_in = 8'h00;
  // Offset is below DEPTH, so low-order subtraction is exact.
  assign wr_off      = bus_address[AW-1:0] - sm_start[AW-1:0];
  assign last_wr     = bus_match && (addr_x == win_end);
  assign en_fall     = en_q && !sm_enable;

  // PDI read FSM
  pdi_state_t state, state_nxt;
  logic       issued, clr_armed, oob_q, pdi_issue;
  logic [7:0] pdi_addr_q, pdi_data_q, ram_rdata;
  logic [AW-1:0] ram_addr;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pdi_issue = 1'b0;
    case (state)
      PDI_IDLE: if (pdi_rd) begin
        state_nxt = PDI_READ;
        pdi_issue = !bus_match;
      end
      // READ waits until its RAM access has actually been issued; an ECAT
      // write owns the single port and pushes the access back a cycle.
      PDI_READ: if (issued) state_nxt = PDI_ACK;
                else        pdi_issue = !bus_match;
      PDI_ACK:  state_nxt = PDI_IDLE;
      default:  state_nxt = PDI_IDLE;
    endcase
    if (en_fall) state_nxt = PDI_IDLE;
  end

  // NOTE: state is a flop, so it takes a non-blocking assignment; blocking
  // here would let readers in other processes race the update.
  always_ff @(posedge rxc) begin
    if (RST) state <= PDI_IDLE;
    else     state <= state_nxt;
  end

  // Request bookkeeping; only meaningful once the FSM leaves IDLE.
  always_ff @(posedge rxc) begin
    if (state == PDI_IDLE && pdi_rd) begin
      pdi_addr_q <= pdi_addr;
      oob_q      <= (pdi_addr >= sm_len);
      issued     <= !bus_match;
      // A completing ECAT write in the same cycle starts a new mailbox that
      // this read must not release.
      clr_armed  <= (pdi_addr == sm_len - 8'd1) && (pdi_addr < sm_len) && !last_wr;
    end else if (state == PDI_READ) begin
      if (pdi_issue) issued    <= 1'b1;
      if (last_wr)   clr_armed <= 1'b0;
      if (issued)    pdi_data_q <= oob_q ? 8'h00 : ram_rdata;
    end
  end

  always_ff @(posedge rxc) begin
    if (RST) begin
      mbx_full <= 1'b0;
      mbx_irq  <= 1'b0;
      wkc_q    <= 1'b0;
      seen     <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      en_q    <= sm_enable;
      mbx_irq <= last_wr;
      wkc_q   <= bus_match && !seen;
      if (!bus_wr)        seen <= 1'b0;
      else if (bus_match) seen <= 1'b1;
      // Setting wins over the release by a read of the previous buffer.
      if (en_fall)                                     mbx_full <= 1'b0;
      else if (last_wr)                                mbx_full <= 1'b1;
      else if (state == PDI_READ && issued && clr_armed) mbx_full <= 1'b0;
    end
  end

  assign ram_addr  = bus_match            ? wr_off :
                     (state == PDI_IDLE)  ? pdi_addr[AW-1:0] : pdi_addr_q[AW-1:0];
  assign pdi_ack   = (state == PDI_ACK);
  assign pdi_rdata = pdi_ack ? pdi_data_q : 8'h00;
  assign sub_wkc   = {1'b0, wkc_q};

  ethercat_dpram #(.DEPTH(DEPTH)) u_ram (
    .clk   (rxc),
    .we    (bus_match),
    .addr  (ram_addr),
    .wdata (bus_data_out),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ethercat_sm_mailbox.sv
// Directed self-checking bench for ethercat_sm_mailbox.
module tb_ethercat_sm_mailbox;

  logic        rxc = 1'b0;
  logic        RST;
  logic        sm_enable;
  logic [15:0] sm_start;
  logic [7:0]  sm_len;
  logic [15:0] bus_address;
  logic        bus_wr, bus_rd;
  logic [7:0]  bus_data_out, bus_data_in;
  logic        bus_match;
  logic        pdi_rd;
  logic [7:0]  pdi_addr, pdi_rdata;
  logic        pdi_ack, mbx_full, mbx_irq;
  logic [1:0]  sub_wkc;

  int n_checks = 0;
  int n_fail   = 0;

  ethercat_sm_mailbox dut (
    .rxc(rxc), .RST(RST), .sm_enable(sm_enable), .sm_start(sm_start),
    .sm_len(sm_len), .bus_address(bus_address), .bus_wr(bus_wr),
    .bus_rd(bus_rd), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_match(bus_match), .pdi_rd(pdi_rd), .pdi_addr(pdi_addr),
    .pdi_rdata(pdi_rdata), .pdi_ack(pdi_ack), .mbx_full(mbx_full),
    .mbx_irq(mbx_irq), .sub_wkc(sub_wkc)
  );

  always #5 rxc = ~rxc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rxc);
    #1;
  endtask

  // Issues a PDI read in the current cycle and waits (bounded) for pdi_ack.
  task automatic pdi_read(input logic [7:0] a, input logic [7:0] exp_data,
                          input int exp_lat, input logic exp_full);
    int lat;
    pdi_rd   = 1'b1;
    pdi_addr = a;
    lat      = 0;
    do begin
      step();
      pdi_rd = 1'b0;
      bus_wr = 1'b0;
      lat++;
    end while (!pdi_ack && lat < 8);
    check("pdi_latency", lat, exp_lat);
    check("pdi_rdata", pdi_rdata, exp_data);
    check("full_at_ack", mbx_full, exp_full);
    step();
    check("ack_one_cycle", pdi_ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] wdat [4];
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;

    RST = 1'b1; sm_enable = 1'b1; sm_start = 16'h1000; sm_len = 8'd4;
    bus_address = 16'h1000; bus_wr = 1'b1; bus_rd = 1'b0; bus_data_out = 8'hAA;
    pdi_rd = 1'b0; pdi_addr = 8'h00;
    step(); step();
    check("rst_full", mbx_full, 1'b0);
    check("rst_irq", mbx_irq, 1'b0);
    check("rst_ack", pdi_ack, 1'b0);
    check("rst_rdata", pdi_rdata, 8'h00);
    check("rst_wkc", sub_wkc, 2'd0);
    check("rst_match", bus_match, 1'b0);
    bus_wr = 1'b0; RST = 1'b0;
    step();

    // Fill the 4-byte mailbox in one datagram.
    for (int i = 0; i < 4; i++) begin
      bus_wr = 1'b1; bus_address = 16'h1000 + 16'(i); bus_data_out = wdat[i];
      #1 check("fill_match", bus_match, 1'b1);
      step();
      check("fill_wkc", sub_wkc, (i == 0) ? 2'd1 : 2'd0);
      check("fill_full", mbx_full, i == 3);
      check("fill_irq", mbx_irq, i == 3);
    end
    bus_wr = 1'b0;
    step();
    check("irq_pulse_end", mbx_irq, 1'b0);
    check("full_held", mbx_full, 1'b1);

    // Full buffer rejects ECAT writes.
    bus_wr = 1'b1; bus_address = 16'h1000; bus_data_out = 8'h55;
    #1 check("full_reject_match", bus_match, 1'b0);
    step();
    bus_wr = 1'b0;
    check("full_reject_wkc", sub_wkc, 2'd0);
    pdi_read(8'd0, 8'h11, 2, 1'b1);

    // Reading the last byte releases the mailbox with the ack.
    pdi_read(8'd3, 8'h44, 2, 1'b0);

    // Window edges and the read strobe.
    bus_wr = 1'b1; bus_address = 16'h0FFF;
    #1 check("below_window", bus_match, 1'b0);
    bus_address = 16'h1004;
    #1 check("above_window", bus_match, 1'b0);
    bus_wr = 1'b0; bus_rd = 1'b1; bus_address = 16'h1000;
    #1 check("rd_match", bus_match, 1'b0);
    check("rd_data", bus_data_in, 8'h00);
    step();
    bus_rd = 1'b0;

    // ECAT write colliding with a PDI request delays the ack by one cycle.
    bus_wr = 1'b1; bus_address = 16'h1001; bus_data_out = 8'h66;
    pdi_read(8'd2, 8'h33, 3, 1'b0);

    // Final ECAT write during the final PDI read: old data out, buffer full.
    pdi_rd = 1'b1; pdi_addr = 8'd3;
    step();
    pdi_rd = 1'b0;
    bus_wr = 1'b1; bus_address = 16'h1003; bus_data_out = 8'h88;
    #1 check("final_wr_match", bus_match, 1'b1);
    step();
    bus_wr = 1'b0;
    check("both_ack", pdi_ack, 1'b1);
    check("both_rdata", pdi_rdata, 8'h44);
    check("both_full", mbx_full, 1'b1);
    check("both_irq", mbx_irq, 1'b1);
    check("both_wkc", sub_wkc, 2'd1);
    step();
    check("both_full_after", mbx_full, 1'b1);

    // Reset in the middle of a PDI read.
    pdi_rd = 1'b1; pdi_addr = 8'd1;
    step();
    pdi_rd = 1'b0; RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_mid_ack", pdi_ack, 1'b0);
    check("rst_mid_full", mbx_full, 1'b0);
    step();
    check("rst_mid_ack2", pdi_ack, 1'b0);
    step();
    check("rst_mid_ack3", pdi_ack, 1'b0);
    pdi_read(8'd1, 8'h66, 2, 1'b0);
    pdi_read(8'd0, 8'h11, 2, 1'b0);
    pdi_read(8'd3, 8'h88, 2, 1'b0);

    // Single-byte final write, then out-of-window PDI offsets.
    bus_wr = 1'b1; bus_address = 16'h1003; bus_data_out = 8'h99;
    #1 check("single_match", bus_match, 1'b1);
    step();
    bus_wr = 1'b0;
    check("single_full", mbx_full, 1'b1);
    check("single_irq", mbx_irq, 1'b1);
    check("single_wkc", sub_wkc, 2'd1);
    pdi_read(8'd4, 8'h00, 2, 1'b1);
    pdi_read(8'hFF, 8'h00, 2, 1'b1);

    // Disabling the channel aborts the read and drops the mailbox.
    pdi_rd = 1'b1; pdi_addr = 8'd0;
    step();
    pdi_rd = 1'b0; sm_enable = 1'b0;
    step();
    check("dis_ack", pdi_ack, 1'b0);
    check("dis_full", mbx_full, 1'b0);
    step();
    check("dis_ack2", pdi_ack, 1'b0);
    sm_enable = 1'b1;
    step();

    // Window at the top of the address space must not wrap.
    sm_start = 16'hFFFE; bus_wr = 1'b1; bus_address = 16'h0001;
    #1 check("no_wrap", bus_match, 1'b0);
    bus_address = 16'hFFFF;
    #1 check("top_hit", bus_match, 1'b1);
    bus_wr = 1'b0; sm_start = 16'h1000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ethercat_sm_mailbox.md
ETHERCAT_SM_MAILBOX -- requirements
Module: ethercat_sm_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning mailbox buffer size in bytes (power of two, 16..256).
REQ-002 SHALL have port rxc  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port sm_enable  input  1  sync-manager channel enable.
REQ-005 SHALL have port sm_start  input  16  physical start address of window.
REQ-006 SHALL have port sm_len  input  8  window length in bytes (1..DEPTH).
REQ-007 SHALL have port bus_address  input  16  physical address from FMMU.
REQ-008 SHALL have port bus_wr  input  1  ECAT-side write strobe, one byte per cycle.
REQ-009 SHALL have port bus_rd  input  1  ECAT-side read strobe.
REQ-010 SHALL have port bus_data_out  input  8  write data from FMMU.
REQ-011 SHALL have port bus_data_in  output  8  read data to FMMU.
REQ-012 SHALL have port bus_match  output  1  current strobe accepted by this channel.
REQ-013 SHALL have port pdi_rd  input  1  PDI read request.
REQ-014 SHALL have port pdi_addr  input  8  PDI byte offset within window.
REQ-015 SHALL have port pdi_rdata  output  8  PDI read data.
REQ-016 SHALL have port pdi_ack  output  1  PDI read completed.
REQ-017 SHALL have port mbx_full  output  1  buffer holds unread complete mailbox.
REQ-018 SHALL have port mbx_irq  output  1  one-cycle pulse when mbx_full rises.
REQ-019 SHALL have port sub_wkc  output  2  working-counter increment for current datagram.

Function
REQ-020 SHALL decode hit = sm_enable and sm_start <= bus_address <= sm_start+sm_len-1, computed in 17 bits (no wrap past 0xFFFF).
REQ-021 SHALL accept an ECAT write (bus_match=1 same cycle, combinational) only when hit and mbx_full=0; RAM[bus_address-sm_start] updated next edge.
REQ-022 SHALL ignore ECAT writes while mbx_full=1 (bus_match=0, RAM unchanged).
REQ-023 SHALL reject bus_rd (bus_match=0, bus_data_in=0x00): window is write-only from ECAT.
REQ-024 SHALL set mbx_full on the edge after an accepted write to offset sm_len-1, and pulse mbx_irq for exactly that cycle.
REQ-025 SHALL run PDI FSM IDLE->READ->ACK->IDLE: READ captures RAM[pdi_addr], ACK drives pdi_rdata valid with pdi_ack=1 for one cycle (2-cycle latency).
REQ-026 SHALL give ECAT write priority on same-cycle RAM conflict; PDI stays in READ one extra cycle per conflict.
REQ-027 SHALL clear mbx_full on the ACK cycle of a PDI read of offset sm_len-1; pdi_addr >= sm_len returns 0x00 without side effect.
REQ-028 SHALL ignore pdi_rd outside IDLE.
REQ-029 SHALL set sub_wkc=1 on the cycle after the first accepted write of a datagram (bus_wr rising), else 0.
REQ-030 SHALL, on sm_enable falling, clear mbx_full and return PDI FSM to IDLE without pdi_ack.
REQ-031 SHALL treat simultaneous final ECAT write and final PDI ACK: clear from old buffer takes effect, then full sets (net mbx_full=1).

Reset
REQ-032 SHALL on RST=1 at a rising edge drive bus_match, bus_data_in, pdi_rdata, pdi_ack, mbx_full, mbx_irq, sub_wkc to 0 and FSM to IDLE.
REQ-033 SHALL not clear RAM contents on reset.
REQ-034 SHALL abort an in-flight PDI read on reset with no pdi_ack.

Structure
REQ-035 SHALL place PDI FSM state encoding and DEPTH default in shared package ethercat_pkg.
REQ-036 SHALL instantiate one sub-module ethercat_dpram (single-port sync RAM, DEPTH x 8) for the buffer.

Verification
REQ-037 SHALL cover: sm_start=0x1000, sm_len=4, writes 0x11,0x22,0x33,0x44 to 0x1000..0x1003 -> mbx_full=1, mbx_irq one pulse, sub_wkc=1.
REQ-038 SHALL cover: full buffer, write 0x55 to 0x1000 -> bus_match=0, PDI read offset 0 returns 0x11.
REQ-039 SHALL cover: PDI read offset 3 -> pdi_rdata=0x44 after 2 cycles, mbx_full clears same cycle as pdi_ack.
REQ-040 SHALL cover: bus_address 0x0FFF, 0x1004, bus_rd at 0x1000 -> bus_match=0 each.
REQ-041 SHALL cover: ECAT write and pdi_rd same cycle -> pdi_ack delayed to cycle 3.
REQ-042 SHALL cover: RST mid PDI READ -> no pdi_ack, mbx_full=0, RAM retained.
